// File: rtl/mem_arb_2to1_pkg.sv
// rtl/mem_arb_2to1_pkg.sv - shared memory message types and arbiter port-id constants
package mem_arb_2to1_pkg;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    localparam logic [2:0] MEM_REQ_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_REQ_TYPE_WRITE = 3'd1;

    localparam int MEM_ARB_PORT_ID_NBITS = 1;
    localparam logic [MEM_ARB_PORT_ID_NBITS-1:0] MEM_ARB_PORT0 = '0;
    localparam logic [MEM_ARB_PORT_ID_NBITS-1:0] MEM_ARB_PORT1 = MEM_ARB_PORT_ID_NBITS'(1);

endpackage

// File: rtl/mem_arb_route_queue.sv
// rtl/mem_arb_route_queue.sv - in-order FIFO of port ids that routes memory responses
module mem_arb_route_queue
    import mem_arb_2to1_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enq_val,
    input  logic [MEM_ARB_PORT_ID_NBITS-1:0] enq_data,
    input  logic                             deq_val,
    output logic                             full,
    output logic                             empty,
    output logic [MEM_ARB_PORT_ID_NBITS-1:0] head
);

    localparam int PTR_W = $clog2(p_depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(p_depth);

    logic [MEM_ARB_PORT_ID_NBITS-1:0] entry_q [p_depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_enq, do_deq;

    assign full   = (count_q == DEPTH);
    assign empty  = (count_q == '0);
    assign do_enq = enq_val & ~full;
    assign do_deq = deq_val & ~empty;
    assign head   = entry_q[rd_ptr_q];

    // Pointers are exactly log2(depth) bits, so they wrap without compare logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) entry_q[wr_ptr_q] <= enq_data;
    end

endmodule

// File: rtl/mem_arb_2to1.sv
// rtl/mem_arb_2to1.sv - round-robin imem/dmem arbiter onto one in-order memory port
module mem_arb_2to1
    import mem_arb_2to1_pkg::*;
#(
    parameter int p_max_outstanding = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  mem_req_4B_t  req0_msg,
    input  logic         req0_val,
    output logic         req0_rdy,

    input  mem_req_4B_t  req1_msg,
    input  logic         req1_val,
    output logic         req1_rdy,

    output mem_resp_4B_t resp0_msg,
    output logic         resp0_val,
    input  logic         resp0_rdy,

    output mem_resp_4B_t resp1_msg,
    output logic         resp1_val,
    input  logic         resp1_rdy,

    output mem_req_4B_t  memreq_msg,
    output logic         memreq_val,
    input  logic         memreq_rdy,

    input  mem_resp_4B_t memresp_msg,
    input  logic         memresp_val,
    output logic         memresp_rdy
);

    logic [MEM_ARB_PORT_ID_NBITS-1:0] prio_q, prio_d;
    logic [MEM_ARB_PORT_ID_NBITS-1:0] grant_id;
    logic [MEM_ARB_PORT_ID_NBITS-1:0] q_head;
    logic                             q_full, q_empty;
    logic                             memreq_fire, memresp_fire;

    // Port 1 wins when it is the only requester or when prio points at it.
    assign grant_id = (req1_val && (!req0_val || prio_q == MEM_ARB_PORT1)) ? MEM_ARB_PORT1
                                                                           : MEM_ARB_PORT0;

    assign memreq_val  = reset & (req0_val | req1_val) & ~q_full;
    assign memreq_msg  = (grant_id == MEM_ARB_PORT1) ? req1_msg : req0_msg;
    assign req0_rdy    = reset & req0_val & (grant_id == MEM_ARB_PORT0) & memreq_rdy & ~q_full;
    assign req1_rdy    = reset & req1_val & (grant_id == MEM_ARB_PORT1) & memreq_rdy & ~q_full;
    assign memreq_fire = memreq_val & memreq_rdy;

    assign prio_d = memreq_fire ? ~grant_id : prio_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prio_q <= MEM_ARB_PORT0;
        else        prio_q <= prio_d;
    end

    assign resp0_msg    = memresp_msg;
    assign resp1_msg    = memresp_msg;
    assign resp0_val    = memresp_val & ~q_empty & (q_head == MEM_ARB_PORT0);
    assign resp1_val    = memresp_val & ~q_empty & (q_head == MEM_ARB_PORT1);
    assign memresp_rdy  = ~q_empty & ((q_head == MEM_ARB_PORT1) ? resp1_rdy : resp0_rdy);
    assign memresp_fire = memresp_val & memresp_rdy;

    mem_arb_route_queue #(
        .p_depth (p_max_outstanding)
    ) u_route_queue (
        .clk      (clk),
        .rst_n    (reset),
        .enq_val  (memreq_fire),
        .enq_data (grant_id),
        .deq_val  (memresp_fire),
        .full     (q_full),
        .empty    (q_empty),
        .head     (q_head)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk or negedge reset) begin
        if (reset && memresp_val) begin
            assert (!q_empty)
                else $warning("mem_arb_2to1: memresp_val asserted with no request outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_mem_arb_2to1.sv
// tb/tb_mem_arb_2to1.sv - self-checking bench for mem_arb_2to1 with an in-order memory model
`timescale 1ns/1ps
module tb_mem_arb_2to1;
    import mem_arb_2to1_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    mem_req_4B_t  req0_msg, req1_msg, memreq_msg;
    logic         req0_val, req0_rdy, req1_val, req1_rdy;
    mem_resp_4B_t resp0_msg, resp1_msg, memresp_msg;
    logic         resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;

    mem_arb_2to1 #(.p_max_outstanding(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    mem_req_4B_t  memq[$];
    mem_req_4B_t  mq_log[$];
    bit           gp_log[$];
    mem_resp_4B_t r0_log[$];
    mem_resp_4B_t r1_log[$];
    bit mem_en, mem_err;
    bit last_fr0, last_fr1, last_fmr;
    int r1_seen, hs_err;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    function automatic mem_resp_4B_t mem_reply(input mem_req_4B_t r);
        mem_resp_4B_t p;
        p.typ = r.typ; p.opaque = r.opaque; p.test = 2'b00; p.len = r.len;
        p.data = mem_data(r.addr);
        return p;
    endfunction

    function automatic mem_req_4B_t rand_req(input logic [31:0] addr);
        mem_req_4B_t r;
        r.typ = MEM_REQ_TYPE_READ; r.opaque = 8'($urandom); r.addr = addr;
        r.len = 2'd0; r.data = $urandom;
        return r;
    endfunction

    task automatic drive_mem();
        if (mem_err) begin
            memresp_val = 1'b1; memresp_msg = '0;
        end else if (mem_en && memq.size() > 0) begin
            memresp_val = 1'b1; memresp_msg = mem_reply(memq[0]);
        end else begin
            memresp_val = 1'b0; memresp_msg = '0;
        end
    endtask

    task automatic clear_logs();
        mq_log.delete(); gp_log.delete(); r0_log.delete(); r1_log.delete();
        r1_seen = 0; hs_err = 0;
    endtask

    // One clock: observe handshakes mid-cycle, then advance the memory model.
    task automatic step();
        mem_req_4B_t mr;
        bit fmq;
        @(negedge clk);
        last_fr0 = req0_val & req0_rdy;
        last_fr1 = req1_val & req1_rdy;
        fmq      = memreq_val & memreq_rdy;
        last_fmr = memresp_val & memresp_rdy;
        mr       = memreq_msg;
        if (fmq != (last_fr0 | last_fr1) || (last_fr0 && last_fr1)) hs_err++;
        if (fmq) begin mq_log.push_back(mr); gp_log.push_back(last_fr1); end
        if (resp0_val && resp0_rdy) r0_log.push_back(resp0_msg);
        if (resp1_val && resp1_rdy) r1_log.push_back(resp1_msg);
        if (resp1_val) r1_seen++;
        @(posedge clk); #1;
        if (last_fmr) void'(memq.pop_front());
        if (fmq) memq.push_back(mr);
        drive_mem();
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
        memreq_rdy = 0; resp0_rdy = 0; resp1_rdy = 0;
        mem_en = 0; mem_err = 0; memq.delete(); clear_logs(); drive_mem();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_val = 1; req1_val = 1; req0_msg = rand_req(32'h10); req1_msg = rand_req(32'h20);
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1; mem_en = 0; mem_err = 1; drive_mem();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b required=000000",
                     {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy});
        end
    endtask

    task automatic test_single_port();
        mem_req_4B_t msgs[3];
        int n, guard;
        reset_dut();
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1; mem_en = 1; drive_mem();
        for (int i = 0; i < 3; i++) msgs[i] = rand_req(32'(i * 4));
        n = 0; guard = 0;
        while (n < 3 && guard < 20) begin
            req0_msg = msgs[n]; req0_val = 1;
            step();
            if (last_fr0) n++;
            guard++;
        end
        req0_val = 0;
        checks++;
        if (guard !== 3) begin failures++; $display("FAIL single_issue_cycles actual=%0d required=3", guard); end
        guard = 0;
        while (r0_log.size() < 3 && guard < 20) begin step(); guard++; end
        checks++;
        if (mq_log.size() !== 3 || r0_log.size() !== 3) begin
            failures++;
            $display("FAIL single_counts actual=%0d/%0d required=3/3", mq_log.size(), r0_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mq_log[i] !== msgs[i]) begin
                    failures++; $display("FAIL single_memreq_%0d actual=%h required=%h", i, mq_log[i], msgs[i]);
                end
                checks++;
                if (r0_log[i] !== mem_reply(msgs[i])) begin
                    failures++; $display("FAIL single_resp0_%0d actual=%h required=%h", i, r0_log[i], mem_reply(msgs[i]));
                end
            end
        end
        checks++;
        if (r1_seen !== 0) begin failures++; $display("FAIL single_resp1_val actual=%0d required=0", r1_seen); end
        checks++;
        if (hs_err !== 0) begin failures++; $display("FAIL single_handshake actual=%0d required=0", hs_err); end
    endtask

    task automatic test_contention();
        mem_req_4B_t l0[6], l1[6];
        int i0, i1, guard;
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            l0[k] = rand_req(32'($urandom_range(0, 255)) * 4);
            l1[k] = rand_req(32'h1000 + 32'($urandom_range(0, 255)) * 4);
        end
        i0 = 0; i1 = 0; guard = 0;
        while ((i0 < 6 || i1 < 6) && guard < 300) begin
            req0_val = (i0 < 6); req0_msg = l0[(i0 < 6) ? i0 : 5];
            req1_val = (i1 < 6); req1_msg = l1[(i1 < 6) ? i1 : 5];
            memreq_rdy = ($urandom_range(0, 3) != 0);
            resp0_rdy  = ($urandom_range(0, 3) != 0);
            resp1_rdy  = ($urandom_range(0, 3) != 0);
            mem_en     = ($urandom_range(0, 3) != 0);
            drive_mem();
            step();
            if (last_fr0) i0++;
            if (last_fr1) i1++;
            guard++;
        end
        req0_val = 0; req1_val = 0; resp0_rdy = 1; resp1_rdy = 1; mem_en = 1; drive_mem();
        guard = 0;
        while ((r0_log.size() < 6 || r1_log.size() < 6) && guard < 100) begin step(); guard++; end
        checks++;
        if (gp_log.size() !== 12) begin
            failures++; $display("FAIL contention_grants actual=%0d required=12", gp_log.size());
        end
        for (int k = 0; k < gp_log.size(); k++) begin
            checks++;
            if (gp_log[k] !== 1'(k % 2)) begin
                failures++; $display("FAIL contention_order_%0d actual=%0d required=%0d", k, gp_log[k], k % 2);
            end
        end
        checks++;
        if (r0_log.size() !== 6 || r1_log.size() !== 6) begin
            failures++;
            $display("FAIL contention_resp_counts actual=%0d/%0d required=6/6", r0_log.size(), r1_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (r0_log[k] !== mem_reply(l0[k])) begin
                    failures++; $display("FAIL contention_resp0_%0d actual=%h required=%h", k, r0_log[k], mem_reply(l0[k]));
                end
                checks++;
                if (r1_log[k] !== mem_reply(l1[k])) begin
                    failures++; $display("FAIL contention_resp1_%0d actual=%h required=%h", k, r1_log[k], mem_reply(l1[k]));
                end
            end
        end
        checks++;
        if (hs_err !== 0) begin failures++; $display("FAIL contention_handshake actual=%0d required=0", hs_err); end
    endtask

    task automatic test_full();
        mem_req_4B_t l[5];
        int guard;
        reset_dut();
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1; mem_en = 0; drive_mem();
        for (int k = 0; k < 5; k++) l[k] = rand_req(32'h2000 + 32'(k * 4));
        for (int k = 0; k < DEPTH; k++) begin
            req1_msg = l[k]; req1_val = 1;
            step();
            checks++;
            if (last_fr1 !== 1'b1) begin failures++; $display("FAIL full_fill_%0d actual=%b required=1", k, last_fr1); end
        end
        req1_msg = l[4];
        #1;
        checks++;
        if ({memreq_val, req1_rdy} !== 2'b00) begin
            failures++; $display("FAIL full_blocked actual=%b required=00", {memreq_val, req1_rdy});
        end
        step();
        checks++;
        if (last_fr1 !== 1'b0) begin failures++; $display("FAIL full_no_fire actual=%b required=0", last_fr1); end
        mem_en = 1; drive_mem();
        #1;
        checks++;
        if ({memresp_rdy, memreq_val, req1_rdy} !== 3'b100) begin
            failures++; $display("FAIL full_pop_cycle actual=%b required=100", {memresp_rdy, memreq_val, req1_rdy});
        end
        step();
        checks++;
        if ({last_fmr, last_fr1} !== 2'b10) begin
            failures++; $display("FAIL full_pop_fire actual=%b required=10", {last_fmr, last_fr1});
        end
        mem_en = 0; drive_mem();
        #1;
        checks++;
        if ({memreq_val, req1_rdy} !== 2'b11) begin
            failures++; $display("FAIL full_unblocked actual=%b required=11", {memreq_val, req1_rdy});
        end
        step();
        checks++;
        if (last_fr1 !== 1'b1) begin failures++; $display("FAIL full_fifth_fire actual=%b required=1", last_fr1); end
        req1_val = 0; mem_en = 1; drive_mem();
        guard = 0;
        while (r1_log.size() < 5 && guard < 50) begin step(); guard++; end
        checks++;
        if (r1_log.size() !== 5) begin
            failures++; $display("FAIL full_resp_count actual=%0d required=5", r1_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (r1_log[k] !== mem_reply(l[k])) begin
                    failures++; $display("FAIL full_resp_%0d actual=%h required=%h", k, r1_log[k], mem_reply(l[k]));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        mem_req_4B_t a, b;
        int stall;
        reset_dut();
        a = rand_req(32'h3000); b = rand_req(32'h3004);
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 0; mem_en = 0; drive_mem();
        req1_msg = a; req1_val = 1; step(); req1_val = 0;
        req0_msg = b; req0_val = 1; step(); req0_val = 0;
        checks++;
        if (mq_log.size() !== 2) begin failures++; $display("FAIL bp_issue actual=%0d required=2", mq_log.size()); end
        mem_en = 1; drive_mem();
        stall = $urandom_range(2, 6);
        for (int s = 0; s < stall; s++) begin
            #1;
            checks++;
            if ({resp1_val, resp0_val, memresp_rdy} !== 3'b100) begin
                failures++; $display("FAIL bp_stall_%0d actual=%b required=100", s, {resp1_val, resp0_val, memresp_rdy});
            end
            step();
        end
        checks++;
        if (r0_log.size() + r1_log.size() !== 0) begin
            failures++; $display("FAIL bp_no_delivery actual=%0d required=0", r0_log.size() + r1_log.size());
        end
        resp1_rdy = 1;
        #1;
        checks++;
        if (memresp_rdy !== 1'b1) begin failures++; $display("FAIL bp_release actual=%b required=1", memresp_rdy); end
        step(); step();
        checks++;
        if (r1_log.size() !== 1 || r0_log.size() !== 1) begin
            failures++; $display("FAIL bp_counts actual=%0d/%0d required=1/1", r0_log.size(), r1_log.size());
        end else begin
            checks++;
            if (r1_log[0] !== mem_reply(a) || r0_log[0] !== mem_reply(b)) begin
                failures++; $display("FAIL bp_data actual=%h/%h required=%h/%h", r1_log[0], r0_log[0], mem_reply(a), mem_reply(b));
            end
        end
    endtask

    task automatic test_reset_mid();
        mem_req_4B_t c, d;
        int guard;
        reset_dut();
        memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1; mem_en = 0; drive_mem();
        for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 1) == 1) begin req1_msg = rand_req(32'h4000); req1_val = 1; end
            else begin req0_msg = rand_req(32'h4100); req0_val = 1; end
            step();
            req0_val = 0; req1_val = 0;
        end
        checks++;
        if (mq_log.size() !== 3) begin failures++; $display("FAIL rmid_issue actual=%0d required=3", mq_log.size()); end
        req0_val = 1; req1_val = 1; mem_en = 1; drive_mem();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy} !== 6'b0) begin
            failures++;
            $display("FAIL rmid_async_outputs actual=%b required=000000",
                     {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy});
        end
        memq.delete(); req0_val = 0; req1_val = 0; drive_mem(); clear_logs();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (memresp_rdy !== 1'b0) begin failures++; $display("FAIL rmid_empty actual=%b required=0", memresp_rdy); end
        c = rand_req(32'h5000); d = rand_req(32'h5004);
        req0_msg = c; req1_msg = d; req0_val = 1; req1_val = 1;
        step();
        checks++;
        if ({last_fr0, last_fr1} !== 2'b10) begin
            failures++; $display("FAIL rmid_prio actual=%b required=10", {last_fr0, last_fr1});
        end
        req0_val = 0; req1_val = 0;
        guard = 0;
        while (r0_log.size() < 1 && guard < 20) begin step(); guard++; end
        checks++;
        if (r0_log.size() !== 1 || r1_log.size() !== 0) begin
            failures++; $display("FAIL rmid_fresh_counts actual=%0d/%0d required=1/0", r0_log.size(), r1_log.size());
        end else begin
            checks++;
            if (r0_log[0] !== mem_reply(c)) begin
                failures++; $display("FAIL rmid_fresh_data actual=%h required=%h", r0_log[0], mem_reply(c));
            end
        end
    endtask

    task automatic test_protocol_error();
        reset_dut();
        resp0_rdy = 1; resp1_rdy = 1; mem_err = 1; drive_mem();
        #1;
        checks++;
        if ({memresp_rdy, resp0_val, resp1_val} !== 3'b000) begin
            failures++; $display("FAIL perr_outputs actual=%b required=000", {memresp_rdy, resp0_val, resp1_val});
        end
        step();
        checks++;
        if (last_fmr !== 1'b0) begin failures++; $display("FAIL perr_no_pop actual=%b required=0", last_fmr); end
        mem_err = 0; drive_mem();
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_contention();
        test_full();
        test_backpressure();
        test_reset_mid();
        test_protocol_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
